// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/branch/halt controls, instruction-memory port, IF/ID outputs.
// Latency: n/a (wires only); the master side is the fetch stage itself.
// Backpressure: stall is a level hold from the hazard unit; there is no ready/credit return path.
// Ports: stall, branch_taken, branch_target, halt, imem_rdata (into fetch);
//        imem_addr, instr_out, pc_out, valid_out, halted, fetch_count (out of fetch).
interface fetch_stage_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   stall;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   halt;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [PC_WIDTH-1:0]    pc_out;
    logic                   valid_out;
    logic                   halted;
    logic [15:0]            fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, halt, imem_rdata,
        output imem_addr, instr_out, pc_out, valid_out, halted, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, halt, imem_rdata,
        input  imem_addr, instr_out, pc_out, valid_out, halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous-read imem, loads the IF/ID register.
// Latency: first valid instruction 2 cycles after reset release; a taken branch costs one bubble.
// Backpressure: stall freezes PC and IF/ID (imem re-reads the same word); halt stops fetch until reset.
// Ports: clk, reset (async active-low), fif (master side of fetch_stage_if).
module fetch_stage #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master fif
);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    next_pc;
    logic                   load;
    logic                   flush;

    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_out_q;
    logic                   valid_q;
    logic                   halted_q;
    logic [15:0]            count_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!fif.branch_taken && !fif.stall && fif.halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    // Output/control logic. next_pc doubles as the imem address and the
    // next pc_q, so pc_q always names the word arriving on imem_rdata.
    always_comb begin
        next_pc = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            BOOT: next_pc = RESET_PC;
            RUN: begin
                if (fif.branch_taken) begin
                    next_pc = fif.branch_target;
                    flush   = 1'b1;
                end else if (fif.stall) begin
                    next_pc = pc_q;
                end else if (fif.halt) begin
                    flush   = 1'b1;
                end else begin
                    next_pc = pc_q + PC_WIDTH'(1);
                    load    = 1'b1;
                end
            end
            default: next_pc = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= next_pc;
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            halted_q <= (state_d == HALTED);
            if (load) begin
                instr_q  <= fif.imem_rdata;
                pc_out_q <= pc_q;
                valid_q  <= 1'b1;
                count_q  <= count_q + 16'd1;
            end else if (flush) begin
                instr_q  <= NOP_INSTR;
                valid_q  <= 1'b0;
            end
        end
    end

    assign fif.imem_addr   = next_pc;
    assign fif.instr_out   = instr_q;
    assign fif.pc_out      = pc_out_q;
    assign fif.valid_out   = valid_q;
    assign fif.halted      = halted_q;
    assign fif.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/branch traffic.
// Latency: checks each cycle at the falling edge against a behavioural fetch model.
// Backpressure: stall and halt driven by the bench; imem modelled as a 1-cycle synchronous RAM.
module tb_fetch_stage;
    localparam int PW = 16;
    localparam int IW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) fif ();

    fetch_stage #(
        .PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .fif(fif.master)
    );

    logic [15:0] mem [0:65535];
    always @(posedge clk) fif.imem_rdata <= mem[fif.imem_addr];

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: where fetching stands, plus the expected IF/ID contents.
    bit          m_boot, m_halt;
    logic [15:0] m_next;
    logic [15:0] e_instr, e_pc, e_count, e_addr, a_addr;
    logic        e_valid, e_halted;

    task automatic model_reset();
        e_instr = 16'h0000; e_pc = 16'h0000; e_valid = 1'b0; e_halted = 1'b0;
        e_count = 16'd0; m_halt = 1'b0; m_boot = 1'b1; m_next = 16'h0000;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = '0; fif.halt = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock: drive at the falling edge, capture the combinational address,
    // advance the model at the rising edge, return at the next falling edge.
    task automatic step(input bit s, input bit b, input logic [15:0] t, input bit h);
        fif.stall = s; fif.branch_taken = b; fif.branch_target = t; fif.halt = h;
        #1;
        if (m_boot)           e_addr = 16'h0000;
        else if (m_halt)      e_addr = m_next;
        else if (b)           e_addr = t;
        else if (s || h)      e_addr = m_next;
        else                  e_addr = m_next + 16'd1;
        a_addr = fif.imem_addr;
        @(posedge clk);
        if (m_boot) begin
            m_boot = 1'b0;
            m_next = 16'h0000;
        end else if (!m_halt) begin
            if (b) begin
                e_valid = 1'b0; e_instr = 16'h0000; m_next = t;
            end else if (s) begin
                // everything holds
            end else if (h) begin
                e_valid = 1'b0; e_instr = 16'h0000; m_halt = 1'b1; e_halted = 1'b1;
            end else begin
                e_instr = mem[m_next]; e_pc = m_next; e_valid = 1'b1;
                e_count = e_count + 16'd1; m_next = m_next + 16'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = '0; fif.halt = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({fif.instr_out, fif.pc_out, fif.valid_out, fif.halted, fif.fetch_count, fif.imem_addr}
            !== {16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_values: got instr=%h pc=%h v=%b h=%b cnt=%0d addr=%h, exp all zero",
                     fif.instr_out, fif.pc_out, fif.valid_out, fif.halted, fif.fetch_count, fif.imem_addr);
        end
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0, 0);
            vectors++;
            if ({fif.instr_out, fif.pc_out, fif.valid_out, fif.halted, fif.fetch_count, a_addr}
                !== {e_instr, e_pc, e_valid, e_halted, e_count, e_addr}) begin
                miscompares++;
                $display("FAIL seq_cycle%0d: got instr=%h pc=%h v=%b cnt=%0d addr=%h, exp instr=%h pc=%h v=%b cnt=%0d addr=%h",
                         i, fif.instr_out, fif.pc_out, fif.valid_out, fif.fetch_count, a_addr,
                         e_instr, e_pc, e_valid, e_count, e_addr);
            end
            if (i == 1) begin
                vectors++;
                if ({fif.instr_out, fif.pc_out, fif.valid_out} !== {16'h1111, 16'h0000, 1'b1}) begin
                    miscompares++;
                    $display("FAIL first_valid: got instr=%h pc=%h v=%b, exp 1111/0000/1",
                             fif.instr_out, fif.pc_out, fif.valid_out);
                end
            end
        end
        vectors++;
        if ({fif.instr_out, fif.fetch_count} !== {16'h3333, 16'd3}) begin
            miscompares++;
            $display("FAIL count_after_3: got instr=%h cnt=%0d, exp 3333/3", fif.instr_out, fif.fetch_count);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'h0, (i == 1));
            vectors++;
            if ({fif.instr_out, fif.pc_out, fif.valid_out, fif.fetch_count, a_addr}
                !== {16'h2222, 16'h0001, 1'b1, 16'd2, 16'h0002}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got instr=%h pc=%h v=%b cnt=%0d addr=%h, exp 2222/0001/1/2/0002",
                         i, fif.instr_out, fif.pc_out, fif.valid_out, fif.fetch_count, a_addr);
            end
        end
        step(0, 0, 16'h0, 0);
        vectors++;
        if ({fif.instr_out, fif.pc_out, fif.valid_out, fif.fetch_count} !== {16'h3333, 16'h0002, 1'b1, 16'd3}) begin
            miscompares++;
            $display("FAIL stall_release: got instr=%h pc=%h v=%b cnt=%0d, exp 3333/0002/1/3",
                     fif.instr_out, fif.pc_out, fif.valid_out, fif.fetch_count);
        end
    endtask

    task automatic test_branch_during_stall();
        step(1, 1, 16'h0040, 0);
        vectors++;
        if ({fif.instr_out, fif.valid_out, fif.fetch_count, a_addr} !== {16'h0000, 1'b0, 16'd3, 16'h0040}) begin
            miscompares++;
            $display("FAIL branch_bubble: got instr=%h v=%b cnt=%0d addr=%h, exp 0000/0/3/0040",
                     fif.instr_out, fif.valid_out, fif.fetch_count, a_addr);
        end
        step(0, 0, 16'h0, 0);
        vectors++;
        if ({fif.instr_out, fif.pc_out, fif.valid_out} !== {mem[16'h0040], 16'h0040, 1'b1}) begin
            miscompares++;
            $display("FAIL branch_target_load: got instr=%h pc=%h v=%b, exp %h/0040/1",
                     fif.instr_out, fif.pc_out, fif.valid_out, mem[16'h0040]);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want [4];
        want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000; want[3] = 16'h0001;
        step(0, 1, 16'hFFFE, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0, 0);
            vectors++;
            if ({fif.pc_out, fif.instr_out, fif.valid_out} !== {want[i], e_instr, 1'b1}) begin
                miscompares++;
                $display("FAIL wrap%0d: got pc=%h instr=%h v=%b, exp pc=%h instr=%h v=1",
                         i, fif.pc_out, fif.instr_out, fif.valid_out, want[i], e_instr);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(3) == 0), ($urandom_range(9) == 0), 16'($urandom), 0);
            vectors++;
            if ({fif.instr_out, fif.pc_out, fif.valid_out, fif.halted, fif.fetch_count, a_addr}
                !== {e_instr, e_pc, e_valid, e_halted, e_count, e_addr}) begin
                miscompares++;
                $display("FAIL random%0d: got instr=%h pc=%h v=%b cnt=%0d addr=%h, exp instr=%h pc=%h v=%b cnt=%0d addr=%h",
                         i, fif.instr_out, fif.pc_out, fif.valid_out, fif.fetch_count, a_addr,
                         e_instr, e_pc, e_valid, e_count, e_addr);
            end
        end
    endtask

    task automatic test_halt();
        logic [15:0] frozen;
        step(0, 1, 16'h0010, 1);
        vectors++;
        if ({fif.halted, fif.valid_out, a_addr} !== {1'b0, 1'b0, 16'h0010}) begin
            miscompares++;
            $display("FAIL halt_with_branch: got h=%b v=%b addr=%h, exp 0/0/0010", fif.halted, fif.valid_out, a_addr);
        end
        step(0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 1);
        vectors++;
        if ({fif.halted, fif.valid_out, fif.instr_out, a_addr} !== {1'b1, 1'b0, 16'h0000, 16'h0012}) begin
            miscompares++;
            $display("FAIL halt_taken: got h=%b v=%b instr=%h addr=%h, exp 1/0/0000/0012",
                     fif.halted, fif.valid_out, fif.instr_out, a_addr);
        end
        frozen = fif.imem_addr;
        for (int i = 0; i < 6; i++) begin
            step(i[0], 1, 16'($urandom), i[1]);
            vectors++;
            if ({fif.halted, fif.valid_out, fif.fetch_count, a_addr, fif.pc_out}
                !== {1'b1, 1'b0, e_count, frozen, e_pc}) begin
                miscompares++;
                $display("FAIL halted_ignore%0d: got h=%b v=%b cnt=%0d addr=%h pc=%h, exp 1/0/%0d/%h/%h",
                         i, fif.halted, fif.valid_out, fif.fetch_count, a_addr, fif.pc_out, e_count, frozen, e_pc);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 0);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({fif.instr_out, fif.pc_out, fif.valid_out, fif.halted, fif.fetch_count, fif.imem_addr}
            !== {16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000}) begin
            miscompares++;
            $display("FAIL async_reset: got instr=%h pc=%h v=%b h=%b cnt=%0d addr=%h, exp all zero",
                     fif.instr_out, fif.pc_out, fif.valid_out, fif.halted, fif.fetch_count, fif.imem_addr);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 16'h0, 0);
            vectors++;
            if ({fif.instr_out, fif.pc_out, fif.valid_out, fif.halted, fif.fetch_count, a_addr}
                !== {e_instr, e_pc, e_valid, e_halted, e_count, e_addr}) begin
                miscompares++;
                $display("FAIL refetch%0d: got instr=%h pc=%h v=%b cnt=%0d addr=%h, exp instr=%h pc=%h v=%b cnt=%0d addr=%h",
                         i, fif.instr_out, fif.pc_out, fif.valid_out, fif.fetch_count, a_addr,
                         e_instr, e_pc, e_valid, e_count, e_addr);
            end
        end
        vectors++;
        if ({fif.instr_out, fif.pc_out} !== {16'h2222, 16'h0001}) begin
            miscompares++;
            $display("FAIL refetch_data: got instr=%h pc=%h, exp 2222/0001", fif.instr_out, fif.pc_out);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_during_stall();
        test_wrap();
        test_random();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
